// File: rtl/rv32i_types.sv
// rv32i_types: CDB payload type, channel indices and arbiter defaults.
package rv32i_types;
  localparam int NUM_CH_DEF = 5;
  localparam int NUM_PORTS_DEF = 2;
  localparam int BR = 0;
  localparam int DIV = 1;
  localparam int MUL = 2;
  localparam int ALU = 3;
  localparam int LS = 4;
  typedef struct packed {
    logic [4:0]  rob_entry;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
  } cdb_t;
  function automatic cdb_t strip_mem(cdb_t c);
    c.mem_rmask = '0;
    c.mem_wmask = '0;
    return c;
  endfunction
endpackage

// File: rtl/cdb_fifo.sv
// cdb_fifo: per-channel result buffer; ready depends only on occupancy and flush.
module cdb_fifo import rv32i_types::*; #(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push_i,
  input  logic          pop_i,
  input  cdb_t          data_i,
  output cdb_t          head_o,
  output logic [CW-1:0] count_o,
  output logic          ready_o
);
  cdb_t mem_q [DEPTH];
  logic [PW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q;
  logic push, pop;
  assign ready_o = (cnt_q < CW'(DEPTH)) && !flush;
  assign push = push_i && ready_o;
  assign pop = pop_i && (cnt_q != '0);
  assign head_o = mem_q[rd_q];
  assign count_o = cnt_q;
  always_ff @(posedge clk) if (push && !rst) mem_q[wr_q] <= data_i;
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_q + PW'(push);
      rd_q <= rd_q + PW'(pop);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: buffers functional-unit results and broadcasts up to NUM_PORTS per cycle,
// fixed-priority channels first, then round-robin.
module cdb_arbiter import rv32i_types::*; #(
  parameter int                NUM_CH    = NUM_CH_DEF,
  parameter int                NUM_PORTS = NUM_PORTS_DEF,
  parameter int                BUF_DEPTH = 2,
  parameter logic [NUM_CH-1:0] PRIO_MASK = 5'b00001,
  parameter logic [NUM_CH-1:0] MEM_MASK  = 5'b10000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [NUM_CH-1:0]     fu_valid,
  input  cdb_t [NUM_CH-1:0]     fu_result,
  output logic [NUM_CH-1:0]     fu_ready,
  output logic [NUM_PORTS-1:0]  cdb_en,
  output cdb_t [NUM_PORTS-1:0]  cdb_out
);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int RW = $clog2(NUM_CH);
  cdb_t head [NUM_CH];
  logic [CW-1:0] cnt [NUM_CH];
  logic [NUM_CH-1:0] pop;
  logic [RW-1:0] rr_q, rr_d;
  logic [NUM_PORTS-1:0] en_q, en_d;
  cdb_t [NUM_PORTS-1:0] out_q, out_d;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    cdb_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
      .clk(clk), .rst(rst), .flush(flush),
      .push_i(fu_valid[c]), .pop_i(pop[c]), .data_i(fu_result[c]),
      .head_o(head[c]), .count_o(cnt[c]), .ready_o(fu_ready[c])
    );
  end
  // Candidate slots 0..NUM_CH-1 scan priority channels, the rest scan round-robin from rr_q.
  always_comb begin
    int n, ch;
    logic prio;
    pop = '0;
    en_d = '0;
    out_d = '0;
    rr_d = rr_q;
    n = 0;
    ch = 0;
    for (int k = 0; k < 2 * NUM_CH; k++) begin
      prio = k < NUM_CH;
      ch = prio ? k : (int'(rr_q) + k - NUM_CH) % NUM_CH;
      if ((PRIO_MASK[ch] == prio) && (cnt[ch] != '0) && (n < NUM_PORTS)) begin
        pop[ch] = 1'b1;
        en_d[n] = 1'b1;
        out_d[n] = MEM_MASK[ch] ? head[ch] : strip_mem(head[ch]);
        n++;
        if (!prio) rr_d = (ch == NUM_CH - 1) ? '0 : RW'(ch + 1);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q <= '0;
      en_q <= '0;
      out_q <= '0;
    end else if (flush) begin
      en_q <= '0;
      out_q <= '0;
    end else begin
      rr_q <= rr_d;
      en_q <= en_d;
      out_q <= out_d;
    end
  end
  assign cdb_en = en_q;
  assign cdb_out = out_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed and random stimulus against a queue-based reference model.
module tb_cdb_arbiter;
  import rv32i_types::*;
  localparam int NC = 5;
  localparam int NP = 2;
  localparam int DEPTH = 2;
  localparam logic [NC-1:0] PRIO = 5'b00001;
  localparam logic [NC-1:0] MEMM = 5'b10000;
  logic clk = 1'b0;
  logic rst, flush;
  logic [NC-1:0] fu_valid, fu_ready, last_rdy;
  cdb_t [NC-1:0] fu_result;
  logic [NP-1:0] cdb_en;
  cdb_t [NP-1:0] cdb_out;
  cdb_t mq [NC][$];
  int rr = 0;
  int seq = 0;
  int total = 0;
  int bad = 0;
  cdb_arbiter dut (
    .clk(clk), .rst(rst), .flush(flush), .fu_valid(fu_valid), .fu_result(fu_result),
    .fu_ready(fu_ready), .cdb_en(cdb_en), .cdb_out(cdb_out)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask
  task automatic rand_payload();
    for (int i = 0; i < NC; i++) begin
      fu_result[i] = '{rob_entry: 5'($urandom), rd_addr: 5'($urandom), rd_data: 32'(seq),
                       mem_rmask: 4'($urandom), mem_wmask: 4'($urandom)};
      seq++;
    end
  endtask
  task automatic cycle(input logic r, input logic f, input logic [NC-1:0] v);
    logic [NC-1:0] er;
    logic [NP-1:0] nen;
    cdb_t nout [NP];
    int n, ch, last;
    rst = r;
    flush = f;
    fu_valid = v;
    @(negedge clk);
    for (int i = 0; i < NC; i++) er[i] = (mq[i].size() < DEPTH) && !f;
    last_rdy = fu_ready;
    check("fu_ready", 64'(fu_ready), 64'(er));
    nen = '0;
    for (int p = 0; p < NP; p++) nout[p] = '0;
    n = 0;
    last = -1;
    if (r) begin
      for (int i = 0; i < NC; i++) mq[i].delete();
      rr = 0;
    end else if (f) begin
      for (int i = 0; i < NC; i++) mq[i].delete();
    end else begin
      for (int k = 0; k < 2 * NC; k++) begin
        ch = k < NC ? k : (rr + k - NC) % NC;
        if ((k < NC) == PRIO[ch] && mq[ch].size() > 0 && n < NP) begin
          nout[n] = mq[ch].pop_front();
          if (!MEMM[ch]) nout[n] = strip_mem(nout[n]);
          nen[n] = 1'b1;
          n++;
          if (k >= NC) last = ch;
        end
      end
      for (int i = 0; i < NC; i++) if (v[i] && er[i]) mq[i].push_back(fu_result[i]);
      if (last >= 0) rr = (last + 1) % NC;
    end
    @(posedge clk);
    #1;
    check("cdb_en", 64'(cdb_en), 64'(nen));
    for (int p = 0; p < NP; p++) if (nen[p] || r) check("cdb_out", 64'(cdb_out[p]), 64'(nout[p]));
  endtask
  initial begin
    rst = 1'b1;
    flush = 1'b0;
    fu_valid = '0;
    fu_result = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_en", 64'(cdb_en), 64'(0));
    check("reset_out", 64'(cdb_out), 64'(0));
    rst = 1'b0;
    rand_payload();
    fu_result[ALU].rob_entry = 5'd3;
    fu_result[ALU].mem_rmask = 4'hf;
    fu_result[ALU].mem_wmask = 4'h3;
    cycle(0, 0, 5'b01000);
    cycle(0, 0, 5'b00000);
    check("single_en", 64'(cdb_en), 64'(2'b01));
    check("single_rob", 64'(cdb_out[0].rob_entry), 64'(3));
    check("single_mask", 64'({cdb_out[0].mem_rmask, cdb_out[0].mem_wmask}), 64'(0));
    cycle(1, 0, 5'b00000);
    rand_payload();
    for (int i = 0; i < NC; i++) fu_result[i].rob_entry = 5'(i);
    cycle(0, 0, 5'b11111);
    cycle(0, 0, 5'b00000);
    check("cont_c2", 64'({cdb_out[0].rob_entry, cdb_out[1].rob_entry}), 64'({5'd0, 5'd1}));
    cycle(0, 0, 5'b00000);
    check("cont_c3", 64'({cdb_out[0].rob_entry, cdb_out[1].rob_entry}), 64'({5'd2, 5'd3}));
    cycle(0, 0, 5'b00000);
    check("cont_c4_en", 64'(cdb_en), 64'(2'b01));
    check("cont_c4", 64'(cdb_out[0].rob_entry), 64'(4));
    cycle(1, 0, 5'b00000);
    for (int k = 0; k < 3; k++) begin
      rand_payload();
      cycle(0, 0, 5'b11111);
    end
    check("bp_rdy4", 64'(last_rdy[LS]), 64'(0));
    repeat (8) cycle(0, 0, 5'b00000);
    rand_payload();
    cycle(0, 0, 5'b00111);
    rand_payload();
    cycle(0, 1, 5'b11111);
    check("flush_en", 64'(cdb_en), 64'(0));
    repeat (3) cycle(0, 0, 5'b00000);
    rand_payload();
    cycle(0, 0, 5'b11111);
    rand_payload();
    cycle(0, 0, 5'b11111);
    check("mid_en", 64'(cdb_en), 64'(2'b11));
    rand_payload();
    cycle(1, 0, 5'b11111);
    for (int k = 0; k < 400; k++) begin
      rand_payload();
      cycle($urandom_range(0, 49) == 0, $urandom_range(0, 19) == 0, 5'($urandom));
    end
    repeat (2) begin
      rand_payload();
      cycle(0, 0, 5'b11110);
    end
    repeat (6) cycle(0, 0, 5'b00000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
